// File: rtl/branch_predictor_pkg.sv
// Shared constants for the fetch-stage branch predictor: counter states and
// the PC offsets used for sequential fetch and delay-slot fall-through.
package branch_predictor_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_e;

    localparam logic [31:0] FETCH_INC      = 32'd4;
    // Resolved not-taken resumes after the delay slot, which has already issued.
    localparam logic [31:0] DSLOT_FALLTHRU = 32'd8;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with a load, one per predictor entry.
module sat_counter2
    import branch_predictor_pkg::*;
#(
    parameter logic [1:0] INIT = WNT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       up,
    input  logic       load,
    input  logic [1:0] load_val,
    output logic [1:0] cnt
);

    logic [1:0] cnt_q;
    logic [1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) begin
            if (load) begin
                cnt_d = load_val;
            end else if (up) begin
                if (cnt_q != ST) cnt_d = cnt_q + 2'd1;
            end else begin
                if (cnt_q != SNT) cnt_d = cnt_q - 2'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= INIT;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with a tagged target buffer; predicts
// combinationally at fetch and trains from the execute-stage outcome.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int         IDX_W    = 6,
    parameter logic [1:0] CNT_INIT = 2'b01
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] f_pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    input  logic        upd_valid,
    input  logic        upd_is_branch,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        upd_pred_taken,
    input  logic [31:0] upd_pred_target,
    output logic        mispredict,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] miss_cnt
);

    localparam int ENTRIES = 1 << IDX_W;
    localparam int TAG_W   = 30 - IDX_W;

    logic [IDX_W-1:0] f_idx;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] f_tag;
    logic [TAG_W-1:0] upd_tag;
    logic             unused_pc_bits;

    assign f_idx          = f_pc[IDX_W+1:2];
    assign f_tag          = f_pc[31:IDX_W+2];
    assign upd_idx        = upd_pc[IDX_W+1:2];
    assign upd_tag        = upd_pc[31:IDX_W+2];
    assign unused_pc_bits = ^{f_pc[1:0], upd_pc[1:0]};

    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] valid_d;
    logic [TAG_W-1:0]   tag_q    [ENTRIES];
    logic [TAG_W-1:0]   tag_d    [ENTRIES];
    logic [31:0]        target_q [ENTRIES];
    logic [31:0]        target_d [ENTRIES];
    logic [1:0]         cnt_w    [ENTRIES];

    logic upd_fire;
    logic upd_hit;
    logic f_hit;

    assign upd_fire = upd_valid && upd_is_branch;
    assign upd_hit  = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
    assign f_hit    = valid_q[f_idx] && (tag_q[f_idx] == f_tag);

    // Counters train by index alone; an aliasing taken branch restarts at weakly taken.
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_cnt
        sat_counter2 #(
            .INIT(CNT_INIT)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .en       (upd_fire && (upd_idx == IDX_W'(gi))),
            .up       (upd_taken),
            .load     (upd_taken && !upd_hit),
            .load_val (WT),
            .cnt      (cnt_w[gi])
        );
    end

    always_comb begin
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_fire && upd_taken) begin
            valid_d[upd_idx]  = 1'b1;
            tag_d[upd_idx]    = upd_tag;
            target_d[upd_idx] = upd_target;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and target are qualified by valid, so they need no reset.
    always_ff @(posedge clk) begin
        tag_q    <= tag_d;
        target_q <= target_d;
    end

    assign pred_taken  = f_hit && cnt_w[f_idx][1];
    assign pred_target = pred_taken ? target_q[f_idx] : (f_pc + FETCH_INC);

    assign mispredict  = upd_fire &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_pred_target != upd_target)));
    assign redirect_pc = !mispredict ? 32'd0 :
                         (upd_taken ? upd_target : (upd_pc + DSLOT_FALLTHRU));

    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] miss_cnt_q;
    logic [31:0] miss_cnt_d;

    always_comb begin
        branch_cnt_d = branch_cnt_q;
        miss_cnt_d   = miss_cnt_q;
        if (upd_fire && (branch_cnt_q != '1)) branch_cnt_d = branch_cnt_q + 32'd1;
        if (mispredict && (miss_cnt_q != '1)) miss_cnt_d = miss_cnt_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            branch_cnt_q <= '0;
            miss_cnt_q   <= '0;
        end else begin
            branch_cnt_q <= branch_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign branch_cnt = branch_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule
